// File: rtl/img_frame_buf.sv
// img_frame_buf: ping-pong image frame memory for the GIF playback path.
//
// A writer streams wide beats of WORD_PIX pixels into the back buffer. The
// display reads single pixels from the front buffer with one-cycle latency.
// The buffers swap only on vsync once the back buffer holds a complete frame.
// After reset or a clear request, both buffers are zeroed by a sequential
// sweep of one wide word per cycle.
//
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   clear               pulse: abort the fill and zero both buffers
//   busy                high while the zeroing sweep runs
//   wr_valid/wr_ready   write beat handshake
//   wr_data             WORD_PIX pixels; pixel i = wr_data[i*PIX_W +: PIX_W]
//   wr_last             marks the final beat of a (possibly short) frame
//   vsync               display frame-boundary pulse; the swap point
//   frame_valid         front buffer holds a completed frame
//   rd_en, rd_addr      pixel read request into the front buffer
//   rd_data, rd_valid   registered read result, one cycle after rd_en
module img_frame_buf #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned WORD_PIX = 16,
  parameter int unsigned DEPTH    = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  output logic                      busy,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [WORD_PIX*PIX_W-1:0] wr_data,
  input  logic                      wr_last,
  input  logic                      vsync,
  output logic                      frame_valid,
  input  logic                      rd_en,
  input  logic [$clog2(DEPTH)-1:0]  rd_addr,
  output logic [PIX_W-1:0]          rd_data,
  output logic                      rd_valid
);

  localparam int unsigned BEATS   = DEPTH / WORD_PIX;
  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W   = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;
  localparam int unsigned WORDS   = 2 * BEATS;
  localparam int unsigned WADDR_W = $clog2(WORDS);
  localparam int unsigned WORD_W  = WORD_PIX * PIX_W;

  localparam logic [1:0] StClear = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [WADDR_W-1:0] clr_q, clr_d;
  logic               front_q, front_d;
  logic               fv_q, fv_d;
  logic [PIX_W-1:0]   rd_data_q;
  logic               rd_valid_q;

  // Buffer 0 occupies words 0..BEATS-1, buffer 1 words BEATS..2*BEATS-1.
  logic [WORD_W-1:0]  mem [WORDS];
  logic               mem_we;
  logic [WADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0]  mem_wdata;

  logic               complete;
  logic [WADDR_W-1:0] back_base;

  assign busy        = (state_q == StClear);
  assign wr_ready    = (state_q == StFill);
  assign frame_valid = fv_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;

  assign complete  = wr_last || (beat_q == BEAT_W'(BEATS - 1));
  assign back_base = front_q ? '0 : WADDR_W'(BEATS);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    clr_d     = clr_q;
    front_d   = front_q;
    fv_d      = fv_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (clear) begin
      // Any beat offered this cycle is dropped; the sweep starts over.
      state_d = StClear;
      clr_d   = '0;
      beat_d  = '0;
      fv_d    = 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          mem_we    = 1'b1;
          mem_waddr = clr_q;
          if (clr_q == WADDR_W'(WORDS - 1)) begin
            state_d = StFill;
            clr_d   = '0;
            beat_d  = '0;
          end else begin
            clr_d = clr_q + 1'b1;
          end
        end
        StFill: begin
          if (wr_valid) begin
            mem_we    = 1'b1;
            mem_waddr = back_base + WADDR_W'(beat_q);
            mem_wdata = wr_data;
            if (complete) begin
              beat_d = '0;
              // vsync alongside the completing beat swaps at this same edge.
              if (vsync) begin
                front_d = ~front_q;
                fv_d    = 1'b1;
              end else begin
                state_d = StHold;
              end
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (vsync) begin
            front_d = ~front_q;
            fv_d    = 1'b1;
            state_d = StFill;
          end
        end
        default: begin
          state_d = StClear;
          clr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StClear;
      beat_q  <= '0;
      clr_q   <= '0;
      front_q <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      clr_q   <= clr_d;
      front_q <= front_d;
      fv_q    <= fv_d;
    end
  end

  // Storage is deliberately not reset; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read path: always addresses the pre-edge front buffer, so a read in the
  // swap cycle still sees the old frame.
  logic [BEAT_W-1:0]  rd_beat;
  logic [OFF_W-1:0]   rd_pix;
  logic [WADDR_W-1:0] rd_waddr;
  logic [WORD_W-1:0]  rd_word;
  logic [PIX_W-1:0]   rd_pixel;
  logic               rd_zero;

  assign rd_beat  = BEAT_W'(rd_addr >> OFF_W);
  assign rd_pix   = OFF_W'(rd_addr);
  assign rd_waddr = (front_q ? WADDR_W'(BEATS) : '0) + WADDR_W'(rd_beat);
  assign rd_word  = mem[rd_waddr];
  assign rd_pixel = rd_word[int'(rd_pix) * PIX_W +: PIX_W];
  assign rd_zero  = busy || !fv_q || (32'(rd_addr) >= DEPTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_zero ? '0 : rd_pixel;
      end
    end
  end

endmodule

// File: tb/tb_img_frame_buf.sv
// Self-checking bench for img_frame_buf at default parameters.
// A frame-level model (two pixel arrays, a sweep countdown, a "back buffer
// full" flag) predicts every output each cycle; directed steps add literal
// expectations for the key pixels and timing points.
module tb_img_frame_buf;
  localparam int DP = 1024;
  localparam int NB = 64;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         clear = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_last = 1'b0;
  logic         vsync = 1'b0;
  logic         rd_en = 1'b0;
  logic [127:0] wr_data = '0;
  logic [9:0]   rd_addr = '0;
  logic         busy, wr_ready, frame_valid, rd_valid;
  logic [7:0]   rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  img_frame_buf dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .busy       (busy),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .vsync      (vsync),
    .frame_valid(frame_valid),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0] m_pix [2][DP];
  int         m_clr   = 2 * NB;  // sweep cycles still to run
  bit         m_have  = 1'b0;    // front holds a completed frame
  int         m_front = 0;
  bit         m_full  = 1'b0;    // back buffer holds a completed frame
  int         m_beat  = 0;
  logic       m_rv    = 1'b0;
  logic [7:0] m_rd    = '0;

  task automatic m_zero();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DP; a++) m_pix[b][a] = 8'h00;
  endtask

  initial begin
    m_zero();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_clr = 2 * NB; m_have = 0; m_front = 0; m_full = 0; m_beat = 0;
        m_rv = 0; m_rd = 0; m_zero();
      end else begin
        if (rd_en) begin
          m_rv = 1;
          m_rd = (m_clr > 0 || !m_have || int'(rd_addr) >= DP) ? 8'h00 : m_pix[m_front][rd_addr];
        end else begin
          m_rv = 0;
        end
        if (clear) begin
          m_clr = 2 * NB; m_have = 0; m_full = 0; m_beat = 0; m_zero();
        end else if (m_clr > 0) begin
          m_clr--;
        end else begin
          if (!m_full && wr_valid) begin
            for (int k = 0; k < 16; k++) m_pix[1 - m_front][m_beat * 16 + k] = wr_data[k * 8 +: 8];
            if (wr_last || m_beat == NB - 1) begin
              m_beat = 0; m_full = 1;
            end else begin
              m_beat++;
            end
          end
          if (m_full && vsync) begin
            m_front = 1 - m_front; m_have = 1; m_full = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", busy, m_clr > 0);
    chk("wr_ready", wr_ready, (m_clr == 0) && !m_full);
    chk("frame_valid", frame_valid, m_have);
    chk("rd_valid", rd_valid, m_rv);
    chk("rd_data", rd_data, m_rd);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] mk(input int mode, input int b, input logic [7:0] c);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[k * 8 +: 8] = (mode == 0) ? 8'((b * 16 + k) & 255) : c;
    return d;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!wr_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) chk("wr_ready_timeout", 0, 1);
  endtask

  task automatic put_frame(input int mode, input logic [7:0] c, input int nb, input bit last,
                           input bit vs);
    for (int b = 0; b < nb; b++) begin
      wait_ready();
      wr_valid = 1'b1;
      wr_data  = mk(mode, b, c);
      wr_last  = last && (b == nb - 1);
      vsync    = vs && (b == nb - 1);
      @(negedge clk);
    end
    wr_valid = 1'b0; wr_last = 1'b0; vsync = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic rd_lit(input int addr, input logic [7:0] exp, input string nm);
    rd_en   = 1'b1;
    rd_addr = 10'(addr);
    @(negedge clk);
    rd_en = 1'b0;
    chk({nm, "_valid"}, rd_valid, 1);
    chk(nm, rd_data, exp);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_rv", rd_valid, 0);
    chk("rst_rd", rd_data, 0);
    reset_n = 1'b1;
    count_busy(n);
    chk("init_sweep_len", n, 128);
    @(negedge clk);
    chk("post_sweep_ready", wr_ready, 1);
    chk("post_sweep_fv", frame_valid, 0);
    rd_lit(5, 8'h00, "rd_before_frame");

    // Frame 1: ramp.
    put_frame(0, 8'h00, NB, 1'b0, 1'b0);
    chk("hold_ready", wr_ready, 0);
    pulse_vsync();
    chk("f1_fv", frame_valid, 1);
    rd_lit(17, 8'h11, "f1_a17");
    rd_lit(1023, 8'hFF, "f1_a1023");
    rd_lit(564, 8'h34, "f1_a564");

    // Frame 2: 0xAA, stalled until vsync.
    put_frame(1, 8'hAA, NB, 1'b0, 1'b0);
    wr_valid = 1'b1;
    wr_data  = mk(1, 0, 8'h33);
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", wr_ready, 0);
    end
    wr_valid = 1'b0;
    rd_lit(17, 8'h11, "f2_pre_swap");
    pulse_vsync();
    rd_lit(17, 8'hAA, "f2_a17");
    rd_lit(1023, 8'hAA, "f2_a1023");

    // Frame 3: completing beat, vsync and a read all in one cycle.
    put_frame(1, 8'h77, NB - 1, 1'b0, 1'b0);
    wait_ready();
    wr_valid = 1'b1; wr_data = mk(1, NB - 1, 8'h77); vsync = 1'b1;
    rd_en = 1'b1; rd_addr = 10'd17;
    @(negedge clk);
    wr_valid = 1'b0; vsync = 1'b0; rd_en = 1'b0;
    chk("swap_rd_old", rd_data, 8'hAA);
    chk("swap_ready", wr_ready, 1);
    rd_lit(17, 8'h77, "swap_rd_new");

    // Short frame over a 0x55 back buffer.
    put_frame(1, 8'h55, NB, 1'b0, 1'b1);
    put_frame(1, 8'h55, NB, 1'b0, 1'b1);
    put_frame(1, 8'hC3, 4, 1'b1, 1'b0);
    chk("short_hold", wr_ready, 0);
    pulse_vsync();
    rd_lit(0, 8'hC3, "short_a0");
    rd_lit(63, 8'hC3, "short_a63");
    rd_lit(64, 8'h55, "short_a64");
    rd_lit(1023, 8'h55, "short_a1023");

    // Clear mid-fill on beat 20.
    put_frame(1, 8'h99, 20, 1'b0, 1'b0);
    wait_ready();
    wr_valid = 1'b1; wr_data = mk(1, 20, 8'h99); clear = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; clear = 1'b0;
    chk("clr_busy", busy, 1);
    chk("clr_fv", frame_valid, 0);
    rd_lit(17, 8'h00, "clr_rd_busy");
    count_busy(n);
    chk("clr_sweep_len", n, 127);
    @(negedge clk);
    chk("clr_fv_after", frame_valid, 0);
    put_frame(1, 8'h12, 1, 1'b1, 1'b1);
    rd_lit(0, 8'h12, "clr_new_a0");
    rd_lit(16, 8'h00, "clr_zeroed_a16");

    // Asynchronous reset mid-fill.
    put_frame(0, 8'h00, NB, 1'b0, 1'b1);
    put_frame(1, 8'h44, 10, 1'b0, 1'b0);
    rd_lit(17, 8'h11, "pre_reset_a17");
    #2 reset_n = 1'b0;
    #1;
    chk("async_busy", busy, 1);
    chk("async_wr_ready", wr_ready, 0);
    chk("async_fv", frame_valid, 0);
    chk("async_rv", rd_valid, 0);
    chk("async_rd", rd_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    count_busy(n);
    chk("reset_sweep_len", n, 128);
    @(negedge clk);
    chk("reset_fv_after", frame_valid, 0);
    chk("reset_ready_after", wr_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/img_frame_buf.md
Name: img_frame_buf

Overview:
- Parametrised, double-buffered (ping-pong) image frame memory for the GIF playback path.
- Writer streams wide beats of WORD_PIX pixels into the back buffer with an internal sequential address. The display side reads single pixels from the front buffer with one-cycle latency.
- Buffers swap only at a display frame boundary, so the display never shows a partial frame.
- Memory zeroing is a sequential sweep after reset or on request, not a reset of every word.

Parameters:
PIX_W, 8, bits per pixel
WORD_PIX, 16, pixels per write beat; power of two
DEPTH, 1024, pixels per frame; multiple of WORD_PIX
(derived) BEATS = DEPTH/WORD_PIX; ADDR_W = $clog2(DEPTH); BEAT_W = $clog2(BEATS)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  pulse: abort current fill, zero both buffers
busy  out  1  high while clear sweep runs
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat can be accepted
wr_data  in  WORD_PIX*PIX_W  pixel i = wr_data[i*PIX_W +: PIX_W]
wr_last  in  1  qualifies the beat as the final beat of the frame
vsync  in  1  one-cycle display frame-boundary pulse; swap point
frame_valid  out  1  front buffer holds a completed frame
rd_en  in  1  read request
rd_addr  in  ADDR_W  pixel address in front buffer
rd_data  out  PIX_W  pixel, registered
rd_valid  out  1  rd_data valid, one cycle after rd_en

Behaviour:
- Reset (async, reset_n low):
  - Outputs: busy=1, wr_ready=0, frame_valid=0, rd_data=0, rd_valid=0.
  - Internal: front_sel=0, beat_cnt=0, clr_cnt=0, state=CLEAR.
  - Memory contents are not reset.
- Storage: 2*DEPTH pixels, organised as 2*BEATS wide words.
- Beat acceptance: a beat is accepted when wr_valid & wr_ready. Pixel i of beat b goes to back-buffer address b*WORD_PIX+i.
- State CLEAR:
  - Writes zero to one wide word per cycle, clr_cnt running 0..2*BEATS-1. Takes exactly 2*BEATS cycles (128 at defaults).
  - busy=1, wr_ready=0.
  - Exits to FILL with busy=0 in the cycle after the last word. beat_cnt=0, frame_valid=0.
- State FILL:
  - wr_ready=1. Each accepted beat writes the back buffer and increments beat_cnt.
  - The frame completes on an accepted beat with wr_last=1 or beat_cnt==BEATS-1; both together count as a single completion. beat_cnt then returns to 0 and the state goes to HOLD.
  - Short frame (wr_last early): unwritten pixels keep their prior contents.
- State HOLD:
  - wr_ready=0.
  - On vsync: front_sel toggles, frame_valid=1, state returns to FILL.
- Swap timing:
  - vsync in the same cycle as the completing beat: that beat is committed, then the swap takes effect. State goes straight to FILL and front_sel toggles at that edge.
  - vsync in FILL without a completion: no swap, front unchanged.
- Read path:
  - rd_en in cycle N gives rd_valid=1 and rd_data=front[rd_addr] in cycle N+1.
  - rd_valid=0 and rd_data holds its last value when rd_en=0.
  - rd_addr>=DEPTH returns 0.
  - While busy or frame_valid=0, reads return 0 with rd_valid=1.
  - A read in the swap cycle returns the pre-swap front buffer.
- Clear request:
  - clear in FILL or HOLD: the in-flight beat in the same cycle is discarded. State goes to CLEAR, clr_cnt=0, frame_valid=0.
  - clear during CLEAR restarts the sweep from 0.
- Reset mid-operation: returns immediately to the reset values; the partial frame is lost.
- Write and read never address the same buffer, so there is no read/write collision.

Test Plan:
- Release reset_n -> busy=1 for exactly 128 cycles, then busy=0, wr_ready=1, frame_valid=0. A read of addr 5 -> rd_valid=1, rd_data=0.
- Write 64 beats, byte k of beat b = (b*16+k)&0xFF, then pulse vsync -> frame_valid=1. rd_addr=17 -> rd_data=0x11 next cycle; rd_addr=1023 -> 0xFF.
- Fill a second frame of 0xAA with no vsync -> wr_ready=0 after beat 64 and wr_valid is stalled. Reads still return frame 1 (addr 17 = 0x11). vsync -> addr 17 = 0xAA.
- Completing beat and vsync in the same cycle -> swap that edge. A read issued in that cycle returns old data; the next read returns new data.
- wr_last on beat 3 of a frame over a frame of 0x55 -> HOLD. After vsync, addr 0..63 hold new data and addr 64 = 0x55.
- clear pulse mid-fill (beat 20) -> busy for 128 cycles, frame_valid=0, all reads 0. reset_n low mid-fill -> outputs at reset values asynchronously.
